// File: rtl/mem_burst_responder_if.sv
// mem_burst_responder_if: request, write-beat and read-beat bus between the
// data-path master and the burst responder.
//   req_*  : burst request (start address, direction, beats-1) with valid/ready
//   wr_*   : write beats, master -> responder, valid/ready
//   rd_*   : read beats, responder -> master, valid/ready
//   busy   : burst in progress
//   err    : sticky out-of-range flag, cleared on the next accepted request
interface mem_burst_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              err;

  modport master (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
    input  req_ready, wr_ready, rd_valid, rd_data, busy, err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
    output req_ready, wr_ready, rd_valid, rd_data, busy, err
  );
endinterface

// File: rtl/mem_burst_responder.sv
// mem_burst_responder: serves 1-word-per-cycle read/write bursts against an
// internal synchronous RAM, with the word address auto-incrementing per beat.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : mem_burst_responder_if slave modport (request, write beats,
//         read beats, busy, err)
module mem_burst_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_burst_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_cur_addr;
  logic [8:0]         r_beats_left;   // write beats remaining minus one
  logic [8:0]         r_fetch_left;   // read fetches still to issue
  logic               r_rd_valid;
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_err;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               w_req_ready, w_wr_ready, w_busy;
  logic               w_accept, w_wr_beat, w_fetch, w_consume, w_in_range;
  logic [IDX_W-1:0]   w_idx;

  // Extra top bit so DEPTH == 2^ADDR_W still compares correctly.
  assign w_in_range = ({1'b0, r_cur_addr} < (ADDR_W+1)'(DEPTH));
  assign w_idx      = r_cur_addr[IDX_W-1:0];

  assign w_accept  = bus.req_valid && w_req_ready;
  assign w_wr_beat = bus.wr_valid && w_wr_ready;
  // Single output register: refill when empty or being drained this cycle.
  assign w_fetch   = (r_state == S_READ) && (!r_rd_valid || bus.rd_ready) &&
                     (r_fetch_left != 9'd0);
  assign w_consume = (r_state == S_READ) && r_rd_valid && bus.rd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_wr_ready  = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        w_busy      = 1'b0;
        if (bus.req_valid) w_state_nxt = bus.req_write ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        w_wr_ready = 1'b1;
        if (bus.wr_valid && (r_beats_left == 9'd0)) w_state_nxt = S_IDLE;
      end
      S_READ: begin
        // No fetches left means the register holds the last beat.
        if (w_consume && (r_fetch_left == 9'd0)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_addr   <= '0;
      r_beats_left <= '0;
      r_fetch_left <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cur_addr   <= bus.req_addr;
        r_beats_left <= {1'b0, bus.req_len};
        r_fetch_left <= {1'b0, bus.req_len} + 9'd1;
        r_err        <= 1'b0;
      end
      if (w_wr_beat) begin
        if (!w_in_range) r_err <= 1'b1;
        r_cur_addr <= r_cur_addr + 1'b1;
        if (r_beats_left != 9'd0) r_beats_left <= r_beats_left - 9'd1;
      end
      if (w_fetch) begin
        r_rd_data    <= w_in_range ? r_mem[w_idx] : '0;
        if (!w_in_range) r_err <= 1'b1;
        r_rd_valid   <= 1'b1;
        r_cur_addr   <= r_cur_addr + 1'b1;
        r_fetch_left <= r_fetch_left - 9'd1;
      end else if (w_consume) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  // RAM is not reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (w_wr_beat && w_in_range) r_mem[w_idx] <= bus.wr_data;
  end

  assign bus.req_ready = w_req_ready;
  assign bus.wr_ready  = w_wr_ready;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.busy      = w_busy;
  assign bus.err       = r_err;
endmodule
